// File: rtl/wb_b3_pkg.sv
// Wishbone B3 shared definitions.
// Cycle/burst type codes and slave state encoding.
package wb_b3_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLASSIC,
        ST_BURST,
        ST_ERR
    } wb_state_e;

endpackage

// File: rtl/wb_b3_burst_adr.sv
// Next-word address for B3 registered-feedback bursts.
// Wrap modes only advance the low bits; linear wraps at 2**AW.
module wb_b3_burst_adr
    import wb_b3_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic [AW-1:0] cur_adr,
    input  logic [2:0]    cti,
    input  logic [1:0]    bte,
    output logic [AW-1:0] nxt_adr
);

    logic [AW-1:0] inc;
    logic [AW-1:0] mask;

    assign inc = cur_adr + AW'(1);

    // Select the wrap window and merge incremented low bits.
    always_comb begin
        mask = '1;
        case (bte)
            BTE_WRAP4:  mask = AW'(3);
            BTE_WRAP8:  mask = AW'(7);
            BTE_WRAP16: mask = AW'(15);
            default:    mask = '1;
        endcase
        if (cti == CTI_CONST)
            nxt_adr = cur_adr;
        else
            nxt_adr = (cur_adr & ~mask) | (inc & mask);
    end

endmodule

// File: rtl/wb_b3_burst_ram.sv
// Wishbone B3 burst-capable RAM slave.
// Registered read data, predicted burst addresses, err on faults.
module wb_b3_burst_ram
    import wb_b3_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_SIZE_BYTES = 4096
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                    wb_we_i,
    input  logic [2:0]              wb_cti_i,
    input  logic [1:0]              wb_bte_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    wb_rty_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int MEM_WORDS = MEM_SIZE_BYTES / SEL_WIDTH;
    localparam int WA        = $clog2(MEM_WORDS);
    localparam int LSB       = $clog2(SEL_WIDTH);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    wb_state_e     state;
    wb_state_e     state_nxt;
    logic [WA-1:0] exp_adr;
    logic [WA-1:0] adr_w;
    logic [WA-1:0] adr_nxt;
    logic          req;
    logic          fault;
    logic          mismatch;
    logic          is_burst;
    logic          last;

    assign adr_w    = wb_adr_i[LSB +: WA];
    assign req      = wb_cyc_i & wb_stb_i;
    assign fault    = wb_adr_i >= ADDR_WIDTH'(MEM_SIZE_BYTES);
    assign mismatch = adr_w != exp_adr;
    assign is_burst = (wb_cti_i == CTI_CONST) | (wb_cti_i == CTI_INCR);
    assign last     = (wb_cti_i == CTI_END) | (wb_cti_i == CTI_CLASSIC);

    assign wb_ack_o = req & ((state == ST_CLASSIC)
                    | ((state == ST_BURST) & ~mismatch));
    assign wb_err_o = req & ((state == ST_ERR)
                    | ((state == ST_BURST) & mismatch));
    assign wb_rty_o = 1'b0;

    wb_b3_burst_adr #(.AW(WA)) u_adr (
        .cur_adr (exp_adr),
        .cti     (wb_cti_i),
        .bte     (wb_bte_i),
        .nxt_adr (adr_nxt)
    );

    // Next-state decode for the transfer FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (fault)
                        state_nxt = ST_ERR;
                    else if (is_burst)
                        state_nxt = ST_BURST;
                    else
                        state_nxt = ST_CLASSIC;
                end
            end
            ST_CLASSIC: begin
                if (!wb_cyc_i || req)
                    state_nxt = ST_IDLE;
            end
            ST_BURST: begin
                if (!wb_cyc_i)
                    state_nxt = ST_IDLE;
                else if (req && (mismatch || last))
                    state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                if (!wb_cyc_i || req)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, predicted address and prefetched read data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            exp_adr  <= '0;
            wb_dat_o <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req) begin
                exp_adr  <= adr_w;
                wb_dat_o <= mem[adr_w];
            end else if (wb_ack_o) begin
                exp_adr  <= adr_nxt;
                wb_dat_o <= mem[adr_nxt];
            end
        end
    end

    // Byte-enabled write on acknowledged write beats.
    always_ff @(posedge clk_i) begin
        if (wb_ack_o && wb_we_i) begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                if (wb_sel_i[i])
                    mem[adr_w][8*i +: 8] <= wb_dat_i[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_wb_b3_burst_ram.sv
// Randomized bench for wb_b3_burst_ram.
// Word-array model, burst addresses from plain arithmetic.
module tb_wb_b3_burst_ram;

    localparam int MSB = 4096;
    localparam int MW  = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic        cyc;
    logic        stb;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_o;
    logic        ack;
    logic        err;
    logic        rty;

    logic [31:0] mem_m [MW];
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    wb_b3_burst_ram #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .MEM_SIZE_BYTES (MSB)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cti_i (cti),
        .wb_bte_i (bte),
        .wb_dat_o (dat_o),
        .wb_ack_o (ack),
        .wb_err_o (err),
        .wb_rty_o (rty)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_wr(input int w, input logic [3:0] s,
                            input logic [31:0] d);
        for (int i = 0; i < 4; i++)
            if (s[i]) mem_m[w][8*i +: 8] = d[8*i +: 8];
    endtask

    function automatic int nxt_w(input int w, input logic [2:0] c,
                                 input logic [1:0] b);
        int n;
        int base;
        if (c == 3'b001) return w;
        if (b == 2'b00) return (w + 1) % MW;
        n    = 2 << b;
        base = w - (w % n);
        return base + ((w % n) + 1) % n;
    endfunction

    task automatic classic(input bit wr, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d,
                           output logic [31:0] rd);
        bit oor;
        int w;
        oor = (a >= 32'(MSB));
        w   = int'(a[11:2]);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = wr; adr = a;
        sel = s; dat_i = d; cti = 3'b000; bte = 2'b00;
        @(negedge clk);
        chk("cl_wait_ack", 32'(ack), 0);
        chk("cl_wait_err", 32'(err), 0);
        @(negedge clk);
        chk("cl_ack", 32'(ack), 32'(!oor));
        chk("cl_err", 32'(err), 32'(oor));
        rd = dat_o;
        if (!oor) begin
            if (wr) model_wr(w, s, d);
            else chk("cl_rdata", dat_o, mem_m[w]);
        end
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic burst(input bit wr, input int start_w, input int nb,
                         input logic [2:0] bcti, input logic [1:0] bbte,
                         input int stall_at, input int bad_at,
                         input int rst_at);
        int          w;
        logic [31:0] d;
        logic [3:0]  s;
        w = start_w;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = wr; adr = 32'(w * 4);
        cti = bcti; bte = bbte; sel = 4'hF; dat_i = $urandom;
        @(negedge clk);
        chk("bu_wait_ack", 32'(ack), 0);
        chk("bu_wait_err", 32'(err), 0);
        for (int b = 0; b < nb; b++) begin
            if (b == stall_at) begin
                for (int k = 0; k < 2; k++) begin
                    @(posedge clk); #1;
                    stb = 0;
                    @(negedge clk);
                    chk("bu_stall_ack", 32'(ack), 0);
                    chk("bu_stall_err", 32'(err), 0);
                end
            end
            @(posedge clk); #1;
            stb = 1;
            if (b == bad_at) adr = 32'(((w + 1) % MW) * 4);
            else adr = 32'(w * 4);
            cti = (b == nb - 1) ? 3'b111 : bcti;
            s = wr ? 4'($urandom) : 4'hF;
            d = $urandom;
            sel = s; dat_i = d;
            if (b == rst_at) rst = 1;
            @(negedge clk);
            if (b == rst_at) begin
                @(posedge clk); #1;
                rst = 0;
                @(negedge clk);
                chk("rst_ack", 32'(ack), 0);
                chk("rst_dat", dat_o, 0);
                break;
            end
            if (b == bad_at) begin
                chk("bad_err", 32'(err), 1);
                chk("bad_ack", 32'(ack), 0);
                break;
            end
            chk("bu_ack", 32'(ack), 1);
            chk("bu_err", 32'(err), 0);
            if (wr) model_wr(w, s, d);
            else chk("bu_rdata", dat_o, mem_m[w]);
            w = nxt_w(w, bcti, bbte);
        end
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0; cti = 3'b000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] w0;
        int          kind;
        int          nb;
        rst = 1; cyc = 0; stb = 0; we = 0; adr = 0;
        dat_i = 0; sel = 0; cti = 0; bte = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack0", 32'(ack), 0);
        chk("rst_err0", 32'(err), 0);
        chk("rst_rty0", 32'(rty), 0);
        chk("rst_dat0", dat_o, 0);
        @(posedge clk); #1;
        rst = 0;

        burst(1, 0, MW, 3'b010, 2'b00, -1, -1, -1);

        classic(1, 32'h10, 4'hF, 32'hDEADBEEF, rd);
        classic(0, 32'h10, 4'hF, 32'h0, rd);
        chk("full_rd", rd, 32'hDEADBEEF);
        classic(1, 32'h10, 4'b0010, 32'h0000AB00, rd);
        classic(0, 32'h10, 4'hF, 32'h0, rd);
        chk("byte_rd", rd, 32'hDEADABEF);

        burst(0, 8, 4, 3'b010, 2'b00, -1, -1, -1);
        burst(0, 14, 4, 3'b010, 2'b01, 2, -1, -1);
        burst(0, MW - 2, 4, 3'b010, 2'b00, -1, -1, -1);

        w0 = mem_m[0];
        classic(1, 32'h1000, 4'hF, ~w0, rd);
        classic(0, 32'h0, 4'hF, 32'h0, rd);
        chk("oor_keep", rd, w0);

        burst(0, 8, 4, 3'b010, 2'b00, -1, 1, -1);
        classic(0, 32'h20, 4'hF, 32'h0, rd);
        burst(0, 20, 6, 3'b010, 2'b00, -1, -1, 2);
        classic(0, 32'h50, 4'hF, 32'h0, rd);

        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: classic(0, {20'h0, 10'($urandom), 2'b00},
                           4'hF, 32'h0, rd);
                1: classic(1, {20'h0, 10'($urandom), 2'b00},
                           4'($urandom), $urandom, rd);
                2: begin
                    nb = $urandom_range(2, 8);
                    burst(1'($urandom),
                          $urandom_range(0, MW - 1), nb,
                          ($urandom_range(0, 3) == 0) ? 3'b001 : 3'b010,
                          2'($urandom),
                          ($urandom_range(0, 2) == 0)
                              ? $urandom_range(0, nb - 1) : -1,
                          ($urandom_range(0, 3) == 0)
                              ? $urandom_range(0, nb - 1) : -1,
                          -1);
                end
                default: classic(1'($urandom),
                                 32'(MSB) + {14'h0, 16'($urandom), 2'b00},
                                 4'hF, $urandom, rd);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_b3_burst_ram.md
Name: wb_b3_burst_ram

Overview:
Wishbone B3 slave (responder) backed by an internal word-organised RAM. It sits on one slave port of the shared Wishbone B3 bus interconnect. It serves classic cycles and registered-feedback bursts: constant-address, incrementing linear, and wrap4/8/16. A burst streams one beat per clock. Out-of-range and mispredicted accesses are answered with err.

Parameters:
DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
ADDR_WIDTH, 32, byte address width.
MEM_SIZE_BYTES, 4096, RAM size in bytes; must be a power of two and a multiple of DATA_WIDTH/8.
SEL_WIDTH (localparam), DATA_WIDTH/8, byte-select width.
MEM_WORDS (localparam), MEM_SIZE_BYTES/SEL_WIDTH.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
wb_adr_i  in  ADDR_WIDTH  byte address; word index = adr[log2(MEM_SIZE_BYTES)-1:log2(SEL_WIDTH)]
wb_dat_i  in  DATA_WIDTH  write data
wb_cyc_i  in  1  cycle valid
wb_stb_i  in  1  strobe
wb_sel_i  in  SEL_WIDTH  byte enables
wb_we_i  in  1  write enable
wb_cti_i  in  3  cycle type (000 classic, 001 const, 010 incr, 111 end)
wb_bte_i  in  2  burst type (00 linear, 01 wrap4, 10 wrap8, 11 wrap16)
wb_dat_o  out  DATA_WIDTH  read data (registered)
wb_ack_o  out  1  acknowledge
wb_err_o  out  1  error
wb_rty_o  out  1  retry; tied to 0

Behaviour:
- Interface decision: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset: state IDLE, wb_dat_o=0, ack/err/rty=0. RAM contents are not reset.
- Reset asserted mid-burst: the next cycle is IDLE with no ack. The master must restart the access.
- req = wb_cyc_i & wb_stb_i. Range fault = wb_adr_i >= MEM_SIZE_BYTES (upper bits nonzero).
- States: IDLE, CLASSIC, BURST, ERR.
- ack_o = req & (state==CLASSIC | (state==BURST & !mismatch)).
- err_o = req & (state==ERR | (state==BURST & mismatch)).
- This gating gives zero ack/err whenever stb is low.
- IDLE, on req:
  - range fault -> ERR.
  - cti==001 or 010 -> BURST.
  - otherwise -> CLASSIC.
  - In the same edge, wb_dat_o <= mem[word(wb_adr_i)] and exp_adr <= word(wb_adr_i).
- CLASSIC: one ack beat, then IDLE. Latency is 1 wait cycle, i.e. ack in the cycle after stb is first seen. Throughput is 1 transfer per 2 cycles.
- Burst address prediction, at each edge with ack_o=1:
  - exp_adr <= next(exp_adr).
  - wb_dat_o <= mem[next(exp_adr)], so the next beat's data is ready in the following cycle.
- next():
  - cti==001: same word.
  - linear: +1 modulo MEM_WORDS (wraps to word 0 at the end of RAM).
  - wrapN: low log2(N) bits incremented modulo N, upper bits preserved.
- BURST, per beat: mismatch = word(wb_adr_i) != exp_adr.
- BURST exit at the edge of an ack cycle:
  - cti==111 -> IDLE.
  - cti==000 -> IDLE.
- BURST, other events:
  - Master wait state (stb low, cyc high): state and exp_adr hold; no ack.
  - cyc low: IDLE.
  - Mismatch: err for that beat -> IDLE; no write.
- ERR: one err beat (gated by req) -> IDLE. No write occurs.
- Writes commit only at edges with ack_o & wb_we_i: bytes of mem[word(wb_adr_i)] enabled by wb_sel_i take wb_dat_i.
- Read-after-write in a burst: a write to word k followed by a read of word k+1 is unaffected.
- Read data for a beat never reflects a write committed in that same edge; the RAM is read-before-write.
- Simultaneous cti==111 and a range fault cannot occur within a burst, because prediction wraps inside the RAM.

Decomposition:
- Package wb_b3_pkg: CTI_CLASSIC/CTI_CONST/CTI_INCR/CTI_END and BTE_LINEAR/BTE_WRAP4/8/16 constants, plus a state enum typedef. It is shared with future B3 masters and slaves.
- Sub-module wb_b3_burst_adr: combinational next-word-address generator (inputs: word address, cti, bte; parameter: word-address width). It is reusable by burst-capable masters.
- RAM is an inferred array inside the top module.

Test Plan:
- Classic write 0xDEADBEEF, sel=1111, to 0x10; then classic read of 0x10 -> ack one cycle after stb each time; read data 0xDEADBEEF; err=0.
- Byte write sel=0010, dat 0x0000AB00, to 0x10 -> subsequent read returns 0xDEADABEF.
- Incrementing linear read burst from 0x20, 4 beats, last beat cti=111 -> ack on 4 consecutive cycles; data = words 8,9,10,11; IDLE afterwards.
- Wrap4 read burst starting at 0x38 (word 14) -> data order words 14,15,12,13; ack every cycle. The master stalling stb for 2 cycles mid-burst gives no ack and no address advance during the stall.
- Out-of-range: adr=0x1000 with MEM_SIZE_BYTES=4096 -> err for one cycle, no ack, and RAM is unchanged (verified by reading word 0).
- Burst with a wrong address on beat 2 (0x28 instead of 0x24) -> err on that beat, state IDLE. Also: rst_i asserted mid-burst -> ack=0 on the next cycle and wb_dat_o=0.
